// File: rtl/instr_fetch_sequencer_pkg.sv
// Shared types for the instruction fetch/decode front end.
package pkg_instr_dec;

  // Instruction group classification of the high instruction word.
  typedef enum logic [2:0] {
    instr_grp_unknown = 3'd0,
    instr_grp_1       = 3'd1,
    instr_grp_2       = 3'd2,
    instr_grp_3       = 3'd3,
    instr_grp_4       = 3'd4,
    instr_grp_5       = 3'd5
  } instr_group;

  // Fetch sequencer states.
  typedef enum logic [1:0] {
    ST_START    = 2'd0,
    ST_FETCH_HI = 2'd1,
    ST_FETCH_LO = 2'd2,
    ST_ISSUE    = 2'd3
  } ifs_state;

endpackage

// File: rtl/instr_fetch_sequencer_group_decoder.sv
// Classifies a high instruction word into its group by the top opcode nibble.
//   0x0-0x3 grp_1, 0x4-0x7 grp_2, 0x8-0xB grp_3, 0xC-0xD grp_4,
//   0xE grp_5 (carries a second immediate word), 0xF unknown.
module instr_group_decoder
  import pkg_instr_dec::*;
(
  input  logic [15:0] instr_word,
  output instr_group  instr_grp
);

  // Decode the opcode nibble.
  always_comb begin
    instr_grp = instr_grp_unknown;
    case (instr_word[15:12])
      4'h0, 4'h1, 4'h2, 4'h3: instr_grp = instr_grp_1;
      4'h4, 4'h5, 4'h6, 4'h7: instr_grp = instr_grp_2;
      4'h8, 4'h9, 4'hA, 4'hB: instr_grp = instr_grp_3;
      4'hC, 4'hD:             instr_grp = instr_grp_4;
      4'hE:                   instr_grp = instr_grp_5;
      default:                instr_grp = instr_grp_unknown;
    endcase
  end

endmodule

// File: rtl/instr_fetch_sequencer.sv
// Instruction fetch sequencer: fetches one or two words per instruction,
// classifies the first, and hands the instruction to execute over valid/ready.
// Owns the PC and accepts redirects from execute in any state but ST_START.
module instr_fetch_sequencer
  import pkg_instr_dec::*;
#(
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [15:0]       mem_rdata,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [15:0]       instr_hi,
  output logic [15:0]       instr_lo,
  output instr_group        instr_grp,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_load_value
);

  localparam logic [ADDR_W-1:0] RESET_PC_W = ADDR_W'(RESET_PC);
  localparam logic [ADDR_W-1:0] PC_ONE     = ADDR_W'(1);

  ifs_state          state;
  ifs_state          state_nxt;
  logic [ADDR_W-1:0] pc;
  instr_group        dec_grp;
  logic              redirect;
  logic              hi_take;
  logic              lo_take;

  instr_group_decoder u_dec (
    .instr_word (mem_rdata),
    .instr_grp  (dec_grp)
  );

  // Redirect wins over any same-cycle ack, which is consumed but discarded.
  assign redirect = pc_load && (state != ST_START);
  assign hi_take  = (state == ST_FETCH_HI) && mem_ack && !pc_load;
  assign lo_take  = (state == ST_FETCH_LO) && mem_ack && !pc_load;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_START;
    else        state <= state_nxt;
  end

  // Next-state decode; redirect has priority outside ST_START.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_START:    state_nxt = ST_FETCH_HI;
      ST_FETCH_HI: begin
        if (pc_load)      state_nxt = ST_FETCH_HI;
        else if (mem_ack) state_nxt = (dec_grp == instr_grp_5) ? ST_FETCH_LO : ST_ISSUE;
      end
      ST_FETCH_LO: begin
        if (pc_load)      state_nxt = ST_FETCH_HI;
        else if (mem_ack) state_nxt = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (pc_load || instr_ready) state_nxt = ST_FETCH_HI;
      end
      default:     state_nxt = ST_START;
    endcase
  end

  // Moore outputs decoded from state and pc only.
  always_comb begin
    mem_req     = 1'b0;
    instr_valid = 1'b0;
    case (state)
      ST_FETCH_HI, ST_FETCH_LO: mem_req     = 1'b1;
      ST_ISSUE:                 instr_valid = 1'b1;
      default: ;
    endcase
  end

  assign mem_addr = pc;

  // Program counter: redirect load, else increment per consumed word (wraps).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  pc <= RESET_PC_W;
    else if (redirect)           pc <= pc_load_value;
    else if (hi_take || lo_take) pc <= pc + PC_ONE;
  end

  // Instruction holding registers; untouched while issuing so outputs stay stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_hi  <= '0;
      instr_lo  <= '0;
      instr_grp <= instr_grp_unknown;
      instr_pc  <= RESET_PC_W;
    end else begin
      if (hi_take) begin
        instr_hi  <= mem_rdata;
        instr_pc  <= pc;
        instr_grp <= dec_grp;
        if (dec_grp != instr_grp_5) instr_lo <= '0;
      end
      if (lo_take) instr_lo <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_instr_fetch_sequencer.sv
// Directed bench for instr_fetch_sequencer: a cycle table for the main DUT
// plus short hand sequences for reset behaviour and PC wrap-around.
module tb_instr_fetch_sequencer;
  import pkg_instr_dec::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic        instr_valid;
  logic        instr_ready = 1'b1;
  logic [15:0] instr_hi;
  logic [15:0] instr_lo;
  instr_group  instr_grp;
  logic [15:0] instr_pc;
  logic        pc_load = 1'b0;
  logic [15:0] pc_load_value = '0;
  logic        ack_en = 1'b1;

  logic        rst2_n = 1'b0;
  logic        mem_req2;
  logic [15:0] mem_addr2;
  logic        mem_ack2;
  logic [15:0] mem_rdata2;
  logic        instr_valid2;
  logic [15:0] instr_hi2;
  logic [15:0] instr_lo2;
  instr_group  instr_grp2;
  logic [15:0] instr_pc2;

  logic [15:0] mem [0:65535];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  assign mem_ack    = mem_req & ack_en;
  assign mem_rdata  = mem[mem_addr];
  assign mem_ack2   = mem_req2;
  assign mem_rdata2 = mem[mem_addr2];

  instr_fetch_sequencer #(.ADDR_W(16), .RESET_PC(0)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_hi(instr_hi), .instr_lo(instr_lo), .instr_grp(instr_grp), .instr_pc(instr_pc),
    .pc_load(pc_load), .pc_load_value(pc_load_value)
  );

  instr_fetch_sequencer #(.ADDR_W(16), .RESET_PC(16'hFFFF)) dut2 (
    .clk(clk), .rst_n(rst2_n),
    .mem_req(mem_req2), .mem_addr(mem_addr2), .mem_ack(mem_ack2), .mem_rdata(mem_rdata2),
    .instr_valid(instr_valid2), .instr_ready(1'b1),
    .instr_hi(instr_hi2), .instr_lo(instr_lo2), .instr_grp(instr_grp2), .instr_pc(instr_pc2),
    .pc_load(1'b0), .pc_load_value(16'h0000)
  );

  typedef struct {
    logic        pl;
    logic [15:0] pv;
    logic        rdy;
    logic        ack;
    logic        req;
    logic [15:0] addr;
    logic        vld;
    logic [15:0] hi;
    logic [15:0] lo;
    instr_group  grp;
    logic [15:0] ipc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic pl, logic [15:0] pv, logic rdy, logic ack,
                              logic req, logic [15:0] addr, logic vld,
                              logic [15:0] hi, logic [15:0] lo, instr_group grp,
                              logic [15:0] ipc);
    vec_t v;
    v.pl = pl; v.pv = pv; v.rdy = rdy; v.ack = ack;
    v.req = req; v.addr = addr; v.vld = vld;
    v.hi = hi; v.lo = lo; v.grp = grp; v.ipc = ipc;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  initial begin
    for (int unsigned a = 0; a < 65536; a++) mem[a] = 16'h0000;
    mem[16'h0000] = 16'h1234;
    mem[16'h0001] = 16'h4000;
    mem[16'h0002] = 16'h8000;
    mem[16'h0003] = 16'hC000;
    mem[16'h0004] = 16'hE012;
    mem[16'h0005] = 16'hABCD;
    mem[16'h0006] = 16'hE111;
    mem[16'h0007] = 16'h9999;
    mem[16'h0008] = 16'h7777;
    mem[16'h000A] = 16'hF000;
    mem[16'h000B] = 16'h3456;
    mem[16'h0100] = 16'h5222;
    mem[16'h0200] = 16'hD000;
    mem[16'hFFFF] = 16'hE777;

    //            pl pv       rdy ack  req addr     vld hi        lo        grp                ipc
    vecs.push_back(mk(0, 16'h0000, 1, 1, 0, 16'h0000, 0, 16'h0000, 16'h0000, instr_grp_unknown, 16'h0000));
    vecs.push_back(mk(0, 16'h0000, 1, 1, 1, 16'h0000, 0, 16'h0000, 16'h0000, instr_grp_unknown, 16'h0000));
    vecs.push_back(mk(0, 16'h0000, 1, 1, 0, 16'h0000, 1, 16'h1234, 16'h0000, instr_grp_1,       16'h0000));
    vecs.push_back(mk(0, 16'h0000, 1, 1, 1, 16'h0001, 0, 16'h1234, 16'h0000, instr_grp_1,       16'h0000));
    vecs.push_back(mk(0, 16'h0000, 1, 1, 0, 16'h0000, 1, 16'h4000, 16'h0000, instr_grp_2,       16'h0001));
    vecs.push_back(mk(0, 16'h0000, 1, 1, 1, 16'h0002, 0, 16'h4000, 16'h0000, instr_grp_2,       16'h0001));
    vecs.push_back(mk(0, 16'h0000, 1, 1, 0, 16'h0000, 1, 16'h8000, 16'h0000, instr_grp_3,       16'h0002));
    vecs.push_back(mk(0, 16'h0000, 1, 1, 1, 16'h0003, 0, 16'h8000, 16'h0000, instr_grp_3,       16'h0002));
    vecs.push_back(mk(0, 16'h0000, 1, 1, 0, 16'h0000, 1, 16'hC000, 16'h0000, instr_grp_4,       16'h0003));
    vecs.push_back(mk(0, 16'h0000, 1, 1, 1, 16'h0004, 0, 16'hC000, 16'h0000, instr_grp_4,       16'h0003));
    vecs.push_back(mk(0, 16'h0000, 1, 1, 1, 16'h0005, 0, 16'hE012, 16'h0000, instr_grp_5,       16'h0004));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(0, 16'h0000, 0, 1, 0, 16'h0000, 1, 16'hE012, 16'hABCD, instr_grp_5,     16'h0004));
    vecs.push_back(mk(0, 16'h0000, 1, 1, 0, 16'h0000, 1, 16'hE012, 16'hABCD, instr_grp_5,       16'h0004));
    vecs.push_back(mk(0, 16'h0000, 1, 1, 1, 16'h0006, 0, 16'hE012, 16'hABCD, instr_grp_5,       16'h0004));
    vecs.push_back(mk(1, 16'h0100, 1, 1, 1, 16'h0007, 0, 16'hE111, 16'hABCD, instr_grp_5,       16'h0006));
    vecs.push_back(mk(0, 16'h0000, 1, 0, 1, 16'h0100, 0, 16'hE111, 16'hABCD, instr_grp_5,       16'h0006));
    vecs.push_back(mk(0, 16'h0000, 1, 1, 1, 16'h0100, 0, 16'hE111, 16'hABCD, instr_grp_5,       16'h0006));
    vecs.push_back(mk(1, 16'h0200, 0, 1, 0, 16'h0000, 1, 16'h5222, 16'h0000, instr_grp_2,       16'h0100));
    vecs.push_back(mk(0, 16'h0000, 1, 1, 1, 16'h0200, 0, 16'h5222, 16'h0000, instr_grp_2,       16'h0100));
    vecs.push_back(mk(1, 16'h0008, 1, 1, 0, 16'h0000, 1, 16'hD000, 16'h0000, instr_grp_4,       16'h0200));
    vecs.push_back(mk(1, 16'h000A, 1, 1, 1, 16'h0008, 0, 16'hD000, 16'h0000, instr_grp_4,       16'h0200));
    vecs.push_back(mk(0, 16'h0000, 1, 1, 1, 16'h000A, 0, 16'hD000, 16'h0000, instr_grp_4,       16'h0200));
    vecs.push_back(mk(0, 16'h0000, 1, 1, 0, 16'h0000, 1, 16'hF000, 16'h0000, instr_grp_unknown, 16'h000A));
    vecs.push_back(mk(0, 16'h0000, 1, 1, 1, 16'h000B, 0, 16'hF000, 16'h0000, instr_grp_unknown, 16'h000A));
    vecs.push_back(mk(0, 16'h0000, 1, 1, 0, 16'h0000, 1, 16'h3456, 16'h0000, instr_grp_1,       16'h000B));
    vecs.push_back(mk(0, 16'h0000, 1, 1, 1, 16'h000C, 0, 16'h3456, 16'h0000, instr_grp_1,       16'h000B));

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst_req",   32'(mem_req), 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_hi",    32'(instr_hi), 32'h0);
    chk("rst_lo",    32'(instr_lo), 32'h0);
    chk("rst_grp",   32'(instr_grp), 32'(instr_grp_unknown));
    chk("rst_pc",    32'(instr_pc), 32'h0);

    // Cycle table: row 0 is the cycle in which reset is released.
    rst_n = 1'b1;
    for (int i = 0; i < vecs.size(); i++) begin
      pc_load       = vecs[i].pl;
      pc_load_value = vecs[i].pv;
      instr_ready   = vecs[i].rdy;
      ack_en        = vecs[i].ack;
      #1;
      chk($sformatf("row%0d_req", i),   32'(mem_req), 32'(vecs[i].req));
      if (vecs[i].req)
        chk($sformatf("row%0d_addr", i), 32'(mem_addr), 32'(vecs[i].addr));
      chk($sformatf("row%0d_valid", i), 32'(instr_valid), 32'(vecs[i].vld));
      chk($sformatf("row%0d_hi", i),    32'(instr_hi), 32'(vecs[i].hi));
      chk($sformatf("row%0d_lo", i),    32'(instr_lo), 32'(vecs[i].lo));
      chk($sformatf("row%0d_grp", i),   32'(instr_grp), 32'(vecs[i].grp));
      chk($sformatf("row%0d_ipc", i),   32'(instr_pc), 32'(vecs[i].ipc));
      @(negedge clk);
    end
    pc_load = 1'b0;
    instr_ready = 1'b1;

    // Reset while a request is outstanding drops it immediately.
    ack_en = 1'b0;
    @(negedge clk);
    chk("midrst_pre_req",  32'(mem_req), 32'd1);
    chk("midrst_pre_addr", 32'(mem_addr), 32'h000D);
    rst_n = 1'b0;
    #1;
    chk("midrst_req",   32'(mem_req), 32'd0);
    chk("midrst_valid", 32'(instr_valid), 32'd0);
    chk("midrst_hi",    32'(instr_hi), 32'h0);
    chk("midrst_grp",   32'(instr_grp), 32'(instr_grp_unknown));

    // Redirect in ST_START is ignored.
    ack_en = 1'b1;
    pc_load = 1'b1;
    pc_load_value = 16'h0300;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("start_req", 32'(mem_req), 32'd0);
    @(negedge clk);
    pc_load = 1'b0;
    #1;
    chk("start_ign_req",  32'(mem_req), 32'd1);
    chk("start_ign_addr", 32'(mem_addr), 32'h0000);

    // RESET_PC = 'hFFFF with a group-5 word there: second word from 0.
    @(negedge clk);
    rst2_n = 1'b1;
    #1;
    chk("wrap_start_req", 32'(mem_req2), 32'd0);
    chk("wrap_rst_ipc",   32'(instr_pc2), 32'hFFFF);
    @(negedge clk); #1;
    chk("wrap_hi_req",  32'(mem_req2), 32'd1);
    chk("wrap_hi_addr", 32'(mem_addr2), 32'hFFFF);
    @(negedge clk); #1;
    chk("wrap_lo_req",  32'(mem_req2), 32'd1);
    chk("wrap_lo_addr", 32'(mem_addr2), 32'h0000);
    @(negedge clk); #1;
    chk("wrap_valid", 32'(instr_valid2), 32'd1);
    chk("wrap_hi",    32'(instr_hi2), 32'hE777);
    chk("wrap_lo",    32'(instr_lo2), 32'h1234);
    chk("wrap_grp",   32'(instr_grp2), 32'(instr_grp_5));
    chk("wrap_ipc",   32'(instr_pc2), 32'hFFFF);
    @(negedge clk); #1;
    chk("wrap_next_req",  32'(mem_req2), 32'd1);
    chk("wrap_next_addr", 32'(mem_addr2), 32'h0001);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
